// File: rtl/lot_pkg.sv
// Shared definitions for the parking-lot occupancy tracker: the FSM state
// encoding, the occupancy count width and the default lot capacity.
package lot_pkg;

    localparam int COUNT_W          = 8;
    localparam int DEFAULT_CAPACITY = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        EN1    = 3'd1,
        EN2    = 3'd2,
        EN3    = 3'd3,
        EX1    = 3'd4,
        EX2    = 3'd5,
        EX3    = 3'd6,
        RESYNC = 3'd7
    } state_t;

endpackage

// File: rtl/occupancy_counter.sv
// Saturating occupancy counter: counts up on inc and down on dec, holding at
// CAPACITY and at zero. full/empty are decoded directly from the count.
module occupancy_counter
    import lot_pkg::*;
#(
    parameter int CAPACITY = DEFAULT_CAPACITY
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               inc,
    input  logic               dec,
    output logic [COUNT_W-1:0] count,
    output logic               full,
    output logic               empty
);

    localparam logic [COUNT_W-1:0] CAP_V = COUNT_W'(CAPACITY);

    logic [COUNT_W-1:0] r_count;

    // Occupancy register: saturates at both ends instead of wrapping.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_count <= '0;
        end else if (inc && (r_count != CAP_V)) begin
            r_count <= r_count + 1'b1;
        end else if (dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign count = r_count;
    assign full  = (r_count == CAP_V);
    assign empty = (r_count == '0);

endmodule

// File: rtl/lot_occupancy.sv
// Parking-lot occupancy tracker. Two beam sensors (a = outer, b = inner) feed
// a Moore FSM that recognises complete entry/exit sequences, tolerates cars
// backing out, and falls into RESYNC on impossible input changes.
// Optional feature macro: LOT_OCCUPANCY_ERR_EN adds err (pulse on each RESYNC
// entry) and err_seen (sticky until reset).
module lot_occupancy
    import lot_pkg::*;
#(
    parameter int CAPACITY = DEFAULT_CAPACITY
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               a,
    input  logic               b,
    output logic               enter,
    output logic               exit,
    output logic [COUNT_W-1:0] count,
    output logic               full,
    output logic               empty
`ifdef LOT_OCCUPANCY_ERR_EN
    ,
    output logic               err,
    output logic               err_seen
`endif
);

    state_t      r_state;
    state_t      w_state_next;
    logic [1:0]  w_ab;
    logic        w_enter_next;
    logic        w_exit_next;
    logic        r_enter;
    logic        r_exit;

    assign w_ab         = {a, b};
    assign w_enter_next = (r_state == EN3) && (w_ab == 2'b00);
    assign w_exit_next  = (r_state == EX3) && (w_ab == 2'b00);

    // State register and registered one-cycle entry/exit pulses.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
            r_enter <= 1'b0;
            r_exit  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_enter <= w_enter_next;
            r_exit  <= w_exit_next;
        end
    end

    // Next-state decode: hold on unchanged input, step forward/back on a
    // single-bit change along a path, anything else is a sensor glitch.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: case (w_ab)
                2'b00:   w_state_next = IDLE;
                2'b10:   w_state_next = EN1;
                2'b01:   w_state_next = EX1;
                default: w_state_next = RESYNC;
            endcase
            EN1: case (w_ab)
                2'b10:   w_state_next = EN1;
                2'b11:   w_state_next = EN2;
                2'b00:   w_state_next = IDLE;
                default: w_state_next = RESYNC;
            endcase
            EN2: case (w_ab)
                2'b11:   w_state_next = EN2;
                2'b01:   w_state_next = EN3;
                2'b10:   w_state_next = EN1;
                default: w_state_next = RESYNC;
            endcase
            EN3: case (w_ab)
                2'b01:   w_state_next = EN3;
                2'b00:   w_state_next = IDLE;
                2'b11:   w_state_next = EN2;
                default: w_state_next = RESYNC;
            endcase
            EX1: case (w_ab)
                2'b01:   w_state_next = EX1;
                2'b11:   w_state_next = EX2;
                2'b00:   w_state_next = IDLE;
                default: w_state_next = RESYNC;
            endcase
            EX2: case (w_ab)
                2'b11:   w_state_next = EX2;
                2'b10:   w_state_next = EX3;
                2'b01:   w_state_next = EX1;
                default: w_state_next = RESYNC;
            endcase
            EX3: case (w_ab)
                2'b10:   w_state_next = EX3;
                2'b00:   w_state_next = IDLE;
                2'b11:   w_state_next = EX2;
                default: w_state_next = RESYNC;
            endcase
            RESYNC: begin
                if (w_ab == 2'b00) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = RESYNC;
        endcase
    end

    assign enter = r_enter;
    assign exit  = r_exit;

    // The counter updates on the same edge that raises the pulse, so count
    // and enter/exit change together.
    occupancy_counter #(
        .CAPACITY (CAPACITY)
    ) u_counter (
        .clk   (clk),
        .reset (reset),
        .inc   (w_enter_next),
        .dec   (w_exit_next),
        .count (count),
        .full  (full),
        .empty (empty)
    );

`ifdef LOT_OCCUPANCY_ERR_EN
    logic w_resync_entry;
    logic r_err;
    logic r_err_seen;

    assign w_resync_entry = (w_state_next == RESYNC) && (r_state != RESYNC);

    // Error pulse on each fresh RESYNC entry, plus a sticky flag.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_err      <= 1'b0;
            r_err_seen <= 1'b0;
        end else begin
            r_err      <= w_resync_entry;
            r_err_seen <= r_err_seen | w_resync_entry;
        end
    end

    assign err      = r_err;
    assign err_seen = r_err_seen;
`endif

endmodule

// File: tb/tb_lot_occupancy.sv
// Directed testbench for lot_occupancy. A default-capacity instance carries
// most checks; a CAPACITY=2 instance sharing the same inputs covers full-lot
// saturation. Honors LOT_OCCUPANCY_ERR_EN for the optional error ports.
module tb_lot_occupancy;
    import lot_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       a;
    logic       b;
    logic       enter;
    logic       exit;
    logic [7:0] count;
    logic       full;
    logic       empty;
    logic       enter2;
    logic       exit2;
    logic [7:0] count2;
    logic       full2;
    logic       empty2;
`ifdef LOT_OCCUPANCY_ERR_EN
    logic       err;
    logic       err_seen;
    logic       err2;
    logic       err_seen2;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int n_enter  = 0;
    int n_exit   = 0;
    int n_enter2 = 0;
    int n_both   = 0;

    always #5 clk = ~clk;

    lot_occupancy u_dut (
        .clk      (clk),
        .reset    (reset),
        .a        (a),
        .b        (b),
        .enter    (enter),
        .exit     (exit),
        .count    (count),
        .full     (full),
        .empty    (empty)
`ifdef LOT_OCCUPANCY_ERR_EN
        ,
        .err      (err),
        .err_seen (err_seen)
`endif
    );

    lot_occupancy #(.CAPACITY(2)) u_cap2 (
        .clk      (clk),
        .reset    (reset),
        .a        (a),
        .b        (b),
        .enter    (enter2),
        .exit     (exit2),
        .count    (count2),
        .full     (full2),
        .empty    (empty2)
`ifdef LOT_OCCUPANCY_ERR_EN
        ,
        .err      (err2),
        .err_seen (err_seen2)
`endif
    );

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drive {a,b} at the falling edge, then observe just after the rising edge.
    task automatic cyc(input logic [1:0] ab);
        @(negedge clk);
        {a, b} = ab;
        @(posedge clk);
        #1;
        if (enter)          n_enter++;
        if (exit)           n_exit++;
        if (enter2)         n_enter2++;
        if (enter && exit)  n_both++;
        if (enter2 && exit2) n_both++;
    endtask

    task automatic do_entry();
        cyc(2'b10); cyc(2'b11); cyc(2'b01); cyc(2'b00);
    endtask

    task automatic do_exit();
        cyc(2'b01); cyc(2'b11); cyc(2'b10); cyc(2'b00);
    endtask

    function automatic int st();
        return int'(u_dut.r_state);
    endfunction

    initial begin
        reset = 1'b0;
        a     = 1'b0;
        b     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_count", count, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_enter", enter, 0);
        check("rst_exit", exit, 0);
        check("rst_state", st(), int'(IDLE));
        check("rst_count2", count2, 0);
`ifdef LOT_OCCUPANCY_ERR_EN
        check("rst_err", err, 0);
        check("rst_err_seen", err_seen, 0);
`endif
        @(negedge clk);
        reset = 1'b1;

        // Full-lot saturation on the CAPACITY=2 instance.
        do_entry();
        check("cap2_cnt1", count2, 1);
        check("cap2_full1", full2, 0);
        do_entry();
        check("cap2_cnt2", count2, 2);
        check("cap2_full2", full2, 1);
        n_enter2 = 0;
        do_entry();
        check("cap2_sat_pulse", n_enter2, 1);
        check("cap2_sat_cnt", count2, 2);
        check("cap2_sat_full", full2, 1);
        check("cap16_cnt3", count, 3);
        check("cap16_full", full, 0);

        // Back to an empty lot for the timed entry.
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("rst2_count", count, 0);
        @(negedge clk);
        reset = 1'b1;
        n_enter = 0;
        n_exit  = 0;
        repeat (3) cyc(2'b00);
        repeat (3) cyc(2'b10);
        repeat (3) cyc(2'b11);
        repeat (3) cyc(2'b01);
        check("entry_no_early", enter, 0);
        check("entry_empty_before", empty, 1);
        cyc(2'b00);
        check("entry_pulse", enter, 1);
        check("entry_count", count, 1);
        check("entry_empty_after", empty, 0);
        cyc(2'b00);
        check("entry_pulse_end", enter, 0);
        cyc(2'b00);
        check("entry_pulse_cnt", n_enter, 1);

        // Exit from one car, then an exit from an already empty lot.
        do_exit();
        check("exit_pulse", exit, 1);
        check("exit_count", count, 0);
        check("exit_empty", empty, 1);
        cyc(2'b00);
        check("exit_pulse_end", exit, 0);
        do_exit();
        check("exit_sat_pulse", exit, 1);
        check("exit_sat_count", count, 0);
        check("exit_sat_empty", empty, 1);
        check("exit_pulse_cnt", n_exit, 2);

        // Backing out of both paths, including a deep entry backout.
        n_enter = 0;
        n_exit  = 0;
        cyc(2'b10); cyc(2'b11); cyc(2'b10); cyc(2'b00);
        check("backout_en_state", st(), int'(IDLE));
        cyc(2'b10); cyc(2'b11); cyc(2'b01); cyc(2'b11); cyc(2'b10); cyc(2'b00);
        check("backout_deep_state", st(), int'(IDLE));
        cyc(2'b01); cyc(2'b11); cyc(2'b10); cyc(2'b11); cyc(2'b01); cyc(2'b00);
        check("backout_ex_state", st(), int'(IDLE));
        check("backout_enters", n_enter, 0);
        check("backout_exits", n_exit, 0);
        check("backout_count", count, 0);

        // Double-bit change forces RESYNC until 00 returns.
        cyc(2'b00);
        cyc(2'b11);
        check("resync_enter_state", st(), int'(RESYNC));
`ifdef LOT_OCCUPANCY_ERR_EN
        check("resync_err_pulse", err, 1);
`endif
        cyc(2'b01);
        check("resync_hold_state", st(), int'(RESYNC));
`ifdef LOT_OCCUPANCY_ERR_EN
        check("resync_err_once", err, 0);
        check("resync_err_seen", err_seen, 1);
`endif
        cyc(2'b00);
        check("resync_exit_state", st(), int'(IDLE));
        check("resync_no_pulse", n_enter + n_exit, 0);
`ifdef LOT_OCCUPANCY_ERR_EN
        check("resync_err_seen_hold", err_seen, 1);
`endif

        // Reset with five cars and a partial entry in progress.
        repeat (5) do_entry();
        check("pre_rst_count", count, 5);
        cyc(2'b10);
        cyc(2'b11);
        check("pre_rst_state", st(), int'(EN2));
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_count", count, 0);
        check("midrst_empty", empty, 1);
        check("midrst_enter", enter, 0);
        check("midrst_exit", exit, 0);
        check("midrst_state", st(), int'(IDLE));
`ifdef LOT_OCCUPANCY_ERR_EN
        check("midrst_err_seen", err_seen, 0);
`endif
        @(negedge clk);
        reset = 1'b1;
        {a, b} = 2'b11;
        @(posedge clk);
        #1;
        check("release_11_state", st(), int'(RESYNC));
        cyc(2'b01);
        cyc(2'b00);
        check("release_idle", st(), int'(IDLE));
        n_enter = 0;
        do_entry();
        check("post_rst_entry", n_enter, 1);
        check("post_rst_count", count, 1);

        check("never_both", n_both, 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/lot_occupancy.md
LOT_OCCUPANCY -- requirements
Module: lot_occupancy

Interface
REQ-001 SHALL have parameter CAPACITY, default 16, maximum cars counted (1..255).
REQ-002 SHALL have port clk  input  1  rising-edge clock, sole clock.
REQ-003 SHALL have port reset  input  1  synchronous, active-low reset (asserted when 0, sampled on posedge clk).
REQ-004 SHALL have port a  input  1  outer sensor, already 2-FF synchronized (1 = beam blocked).
REQ-005 SHALL have port b  input  1  inner sensor, already 2-FF synchronized (1 = beam blocked).
REQ-006 SHALL have port enter  output  1  one-cycle pulse per completed entry.
REQ-007 SHALL have port exit  output  1  one-cycle pulse per completed exit.
REQ-008 SHALL have port count  output  8  current occupancy, 0..CAPACITY.
REQ-009 SHALL have port full  output  1  high when count == CAPACITY.
REQ-010 SHALL have port empty  output  1  high when count == 0.

Function
REQ-011 SHALL sample {a,b} each posedge clk and run a Moore FSM with states IDLE, EN1, EN2, EN3, EX1, EX2, EX3, RESYNC.
REQ-012 SHALL follow the entry path IDLE-(10)->EN1-(11)->EN2-(01)->EN3-(00)->IDLE, and the exit path IDLE-(01)->EX1-(11)->EX2-(10)->EX3-(00)->IDLE.
REQ-013 SHALL hold the current state while {a,b} is unchanged.
REQ-014 SHALL support backing out: EN3-(11)->EN2, EN2-(10)->EN1, EN1-(00)->IDLE, EX3-(11)->EX2, EX2-(01)->EX1, EX1-(00)->IDLE, with no pulse on any of these.
REQ-015 SHALL go to RESYNC on any other input from any state (double-bit change, e.g. IDLE with 11), and SHALL leave RESYNC for IDLE only on 00.
REQ-016 SHALL assert enter for exactly one cycle, in the cycle after {a,b}=00 is sampled in EN3; exit likewise from EX3.
REQ-017 SHALL update count in the same cycle the corresponding pulse is high (registered, 1-cycle latency from sample).
REQ-018 SHALL saturate: an entry at count==CAPACITY still pulses enter but leaves count unchanged; an exit at count==0 still pulses exit but leaves count unchanged; no wrap-around.
REQ-019 SHALL derive full and empty combinationally from count.
REQ-020 SHALL never assert enter and exit in the same cycle.

Reset
REQ-021 SHALL, while reset==0 at a posedge, force state=IDLE, count=0, enter=0, exit=0 (so empty=1, full=0).
REQ-022 SHALL abandon any partial sequence on reset mid-operation; after release with {a,b}!=00, the FSM SHALL proceed from IDLE per REQ-012/015.

Configuration
REQ-023 With LOT_OCCUPANCY_ERR_EN defined, SHALL add output err (1 bit, reset 0), a one-cycle pulse on every entry into RESYNC, plus sticky output err_seen, cleared only by reset.
REQ-024 Without LOT_OCCUPANCY_ERR_EN, the err and err_seen ports SHALL be absent and RESYNC behaviour SHALL be otherwise identical.

Structure
REQ-025 SHALL use a shared package lot_pkg holding the FSM state enum typedef, the count width constant (8) and the default CAPACITY.
REQ-026 SHALL instantiate one sub-module, occupancy_counter (inc, dec, CAPACITY -> count, full, empty, saturating), with the FSM in lot_occupancy.

Verification
REQ-027 Reset with count=5 and FSM in EN2 -> next cycle count=0, empty=1, no pulses, state IDLE.
REQ-028 {a,b}=00,10,11,01,00 each held 3 cycles from count=0 -> one enter pulse, 1 cycle after the final 00 is sampled; count=1; empty falls.
REQ-029 {a,b}=00,01,11,10,00 from count=0 -> one exit pulse; count stays 0; empty stays 1.
REQ-030 {a,b}=10,11,10,00 (backout) -> no pulses, count unchanged, FSM back in IDLE.
REQ-031 CAPACITY=2: three full entries -> three enter pulses, count=2, full=1 after the second and unchanged after the third.
REQ-032 {a,b}=00->11->01->00 -> RESYNC, no pulses, IDLE on 00; with LOT_OCCUPANCY_ERR_EN, err pulses once and err_seen stays 1 until reset.
